// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared constants and types for the RMII receive front end.
//   RMII_PREAMBLE_DIBIT  - dibit pattern of a 0x55 preamble byte (LSB-first)
//   RMII_SFD_LAST_DIBIT  - final dibit of the 0xD5 start-of-frame delimiter
//   rx_state_e           - receive FSM states
package eth_rx_pkg;

    localparam logic [1:0] RMII_PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] RMII_SFD_LAST_DIBIT = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } rx_state_e;

endpackage

// File: rtl/eth_rx_d1.sv
// eth_rx_d1: generic WIDTH-bit one-cycle delay register, async active-low reset.
// Ports:
//   c      in   1      clock
//   rst_n  in   1      asynchronous active-low reset, clears q to 0
//   d      in   WIDTH  input
//   q      out  WIDTH  d delayed by one clock
module eth_rx_d1
    import eth_rx_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = d;
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/eth_rx.sv
// eth_rx: RMII (100 Mb/s, 50 MHz refclk) receive front end.
// Strips preamble/SFD and reassembles LSB-first dibits into bytes. Every byte
// after the SFD, FCS included, is delivered; FCS is not checked here.
// Ports:
//   c         in   1  50 MHz RMII reference clock
//   rst_n     in   1  asynchronous active-low reset
//   phy_rxd   in   2  RMII RXD dibit, LSB-first within a byte
//   phy_rxdv  in   1  RMII CRS_DV
//   d         out  8  received byte, valid while dv=1 (held until next byte)
//   dv        out  1  one-cycle strobe per received byte
//   erx       out  1  one-cycle end-of-frame strobe
module eth_rx
    import eth_rx_pkg::*;
(
    input  logic       c,
    input  logic       rst_n,
    input  logic [1:0] phy_rxd,
    input  logic       phy_rxdv,
    output logic [7:0] d,
    output logic       dv,
    output logic       erx
);

    // Input stage: all decisions use the registered pin copies
    logic [2:0] rx_q;
    logic [1:0] rxd_q;
    logic       rxdv_q;

    eth_rx_d1 #(.WIDTH(3)) u_in_d1 (
        .c     (c),
        .rst_n (rst_n),
        .d     ({phy_rxdv, phy_rxd}),
        .q     (rx_q)
    );

    assign rxdv_q = rx_q[2];
    assign rxd_q  = rx_q[1:0];

    // Framing FSM and byte assembly
    rx_state_e  state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] d_q, d_d;
    logic       dv_q, dv_d;
    logic       erx_q, erx_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        dv_d    = 1'b0;
        erx_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxdv_q && (rxd_q == RMII_PREAMBLE_DIBIT)) begin
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                // Any dibit other than the SFD tail keeps us here, which also
                // rides out false-carrier noise from the PHY at startup.
                if (!rxdv_q) begin
                    state_d = IDLE;
                end else if (rxd_q == RMII_SFD_LAST_DIBIT) begin
                    state_d = DATA;
                    cnt_d   = 2'd0;
                end
            end
            DATA: begin
                if (rxdv_q) begin
                    sr_d  = {rxd_q, sr_q[7:2]};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        d_d  = {rxd_q, sr_q[7:2]};
                        dv_d = 1'b1;
                    end
                end else begin
                    // Any partial byte in sr is simply dropped.
                    erx_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register stage
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            dv_q    <= 1'b0;
            erx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            dv_q    <= dv_d;
            erx_q   <= erx_d;
        end
    end

    assign d   = d_q;
    assign dv  = dv_q;
    assign erx = erx_q;

endmodule

// File: tb/tb_eth_rx.sv
module tb_eth_rx;

    logic       c = 1'b0;
    logic       rst_n;
    logic [1:0] phy_rxd;
    logic       phy_rxdv;
    logic [7:0] d;
    logic       dv;
    logic       erx;

    eth_rx dut (
        .c        (c),
        .rst_n    (rst_n),
        .phy_rxd  (phy_rxd),
        .phy_rxdv (phy_rxdv),
        .d        (d),
        .dv       (dv),
        .erx      (erx)
    );

    always #10 c = ~c;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [7:0] rx_bytes[$];
    int         dv_cyc[$];
    int         erx_cnt = 0;
    int         last_erx_cyc = -1;
    int         overlap_cnt = 0;
    logic [7:0] tx[$];

    always @(posedge c) cyc <= cyc + 1;

    // Monitor samples outputs on the falling edge, away from the active edge.
    always @(negedge c) begin
        if (dv === 1'b1) begin
            rx_bytes.push_back(d);
            dv_cyc.push_back(cyc);
        end
        if (erx === 1'b1) begin
            erx_cnt++;
            last_erx_cyc = cyc;
        end
        if (dv === 1'b1 && erx === 1'b1) overlap_cnt++;
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] r;
        r = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = x[31-k];
        return r;
    endfunction

    task automatic clear_mon();
        rx_bytes.delete();
        dv_cyc.delete();
        erx_cnt = 0;
        last_erx_cyc = -1;
        overlap_cnt = 0;
    endtask

    task automatic drive(input logic v, input logic [1:0] r);
        @(posedge c);
        #1;
        phy_rxdv = v;
        phy_rxd  = r;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00);
    endtask

    task automatic send_preamble_sfd();
        repeat (7) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_frame();
        send_preamble_sfd();
        foreach (tx[i]) send_byte(tx[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        phy_rxd = 2'b00;
        phy_rxdv = 1'b0;
        repeat (3) @(posedge c);
        #1;
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_d got=%h exp=00", d); end
        tests_run++;
        if (dv !== 1'b0) begin tests_failed++; $display("FAIL reset_dv got=%b exp=0", dv); end
        tests_run++;
        if (erx !== 1'b0) begin tests_failed++; $display("FAIL reset_erx got=%b exp=0", erx); end
        @(negedge c);
        rst_n = 1'b1;
        clear_mon();
        idle(6);
        tests_run++;
        if (rx_bytes.size() != 0 || erx_cnt != 0) begin
            tests_failed++;
            $display("FAIL idle_quiet dv_count=%0d erx_count=%0d exp=0/0", rx_bytes.size(), erx_cnt);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] got;
        clear_mon();
        tx = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame();
        idle(8);
        tests_run++;
        if (rx_bytes.size() != 4) begin
            tests_failed++;
            $display("FAIL basic_count got=%0d exp=4", rx_bytes.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx;
            tests_run++;
            if (got !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL basic_byte%0d got=%h exp=%h", i, got, exp_b[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            if (i < dv_cyc.size()) begin
                tests_run++;
                if (dv_cyc[i] - dv_cyc[i-1] != 4) begin
                    tests_failed++;
                    $display("FAIL basic_spacing%0d got=%0d exp=4", i, dv_cyc[i] - dv_cyc[i-1]);
                end
            end
        end
        tests_run++;
        if (erx_cnt != 1) begin tests_failed++; $display("FAIL basic_erx got=%0d exp=1", erx_cnt); end
        tests_run++;
        if (dv_cyc.size() == 0 || last_erx_cyc <= dv_cyc[dv_cyc.size()-1]) begin
            tests_failed++;
            $display("FAIL basic_erx_after_dv erx_cyc=%0d last_dv_cyc=%0d", last_erx_cyc,
                     dv_cyc.size() ? dv_cyc[dv_cyc.size()-1] : -1);
        end
        tests_run++;
        if (overlap_cnt != 0) begin tests_failed++; $display("FAIL basic_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    task automatic test_full_frame();
        logic [31:0] crc;
        logic [31:0] fcs;
        int bad;
        clear_mon();
        tx.delete();
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            tx.push_back(8'((i * 7 + 3) & 8'hFF));
            crc = crc_byte(crc, tx[i]);
        end
        fcs = ~crc;
        for (int k = 0; k < 4; k++) tx.push_back(fcs[8*k +: 8]);
        send_frame();
        idle(8);
        tests_run++;
        if (rx_bytes.size() != 64) begin
            tests_failed++;
            $display("FAIL full_count got=%0d exp=64", rx_bytes.size());
        end
        bad = 0;
        crc = 32'hFFFFFFFF;
        foreach (rx_bytes[i]) begin
            if (i < 64 && rx_bytes[i] !== tx[i]) bad++;
            crc = crc_byte(crc, rx_bytes[i]);
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL full_bytes wrong=%0d exp=0", bad); end
        tests_run++;
        if (bitrev32(crc) !== 32'hC704DD7B) begin
            tests_failed++;
            $display("FAIL full_residue got=%h exp=c704dd7b", bitrev32(crc));
        end
        tests_run++;
        if (erx_cnt != 1) begin tests_failed++; $display("FAIL full_erx got=%0d exp=1", erx_cnt); end
    endtask

    task automatic test_partial();
        clear_mon();
        tx = '{8'h11, 8'h22};
        send_frame();
        drive(1'b1, 2'b11);
        drive(1'b1, 2'b00);
        idle(10);
        tests_run++;
        if (rx_bytes.size() != 2) begin
            tests_failed++;
            $display("FAIL partial_count got=%0d exp=2", rx_bytes.size());
        end
        tests_run++;
        if (rx_bytes.size() < 2 || rx_bytes[0] !== 8'h11 || rx_bytes[1] !== 8'h22) begin
            tests_failed++;
            $display("FAIL partial_bytes got=%p exp=11,22", rx_bytes);
        end
        tests_run++;
        if (erx_cnt != 1) begin tests_failed++; $display("FAIL partial_erx got=%0d exp=1", erx_cnt); end
        tests_run++;
        if (overlap_cnt != 0) begin tests_failed++; $display("FAIL partial_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    task automatic test_preamble_only();
        clear_mon();
        repeat (7) send_byte(8'h55);
        idle(10);
        tests_run++;
        if (rx_bytes.size() != 0 || erx_cnt != 0) begin
            tests_failed++;
            $display("FAIL preonly_quiet dv_count=%0d erx_count=%0d exp=0/0", rx_bytes.size(), erx_cnt);
        end
        clear_mon();
        tx = '{8'hA5, 8'h3C, 8'hF0};
        send_frame();
        idle(8);
        tests_run++;
        if (rx_bytes.size() != 3 || rx_bytes[0] !== 8'hA5 || rx_bytes[1] !== 8'h3C || rx_bytes[2] !== 8'hF0) begin
            tests_failed++;
            $display("FAIL preonly_next got=%p exp=a5,3c,f0", rx_bytes);
        end
        tests_run++;
        if (erx_cnt != 1) begin tests_failed++; $display("FAIL preonly_next_erx got=%0d exp=1", erx_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        tx = '{8'h10, 8'h20, 8'h30};
        send_frame();
        idle(48);
        tests_run++;
        if (rx_bytes.size() != 3 || erx_cnt != 1) begin
            tests_failed++;
            $display("FAIL b2b_a dv_count=%0d erx_count=%0d exp=3/1", rx_bytes.size(), erx_cnt);
        end
        clear_mon();
        tx = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        send_frame();
        idle(8);
        tests_run++;
        if (rx_bytes.size() != 5 || erx_cnt != 1) begin
            tests_failed++;
            $display("FAIL b2b_b dv_count=%0d erx_count=%0d exp=5/1", rx_bytes.size(), erx_cnt);
        end
        tests_run++;
        if (rx_bytes.size() != 5 || rx_bytes[0] !== 8'h41 || rx_bytes[4] !== 8'h45) begin
            tests_failed++;
            $display("FAIL b2b_b_bytes got=%p exp=41..45", rx_bytes);
        end
        // Minimum one-cycle gap: second frame starts while erx of the first is high
        clear_mon();
        tx = '{8'hA1, 8'hB2};
        send_frame();
        idle(1);
        tx = '{8'hC3, 8'hD4, 8'hE5};
        send_frame();
        idle(10);
        tests_run++;
        if (rx_bytes.size() != 5 || erx_cnt != 2) begin
            tests_failed++;
            $display("FAIL b2b_gap1 dv_count=%0d erx_count=%0d exp=5/2", rx_bytes.size(), erx_cnt);
        end
        tests_run++;
        if (rx_bytes.size() != 5 || rx_bytes[2] !== 8'hC3 || rx_bytes[3] !== 8'hD4 || rx_bytes[4] !== 8'hE5) begin
            tests_failed++;
            $display("FAIL b2b_gap1_bytes got=%p exp=a1,b2,c3,d4,e5", rx_bytes);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_preamble_sfd();
        send_byte(8'h3C);
        send_byte(8'h5A);
        drive(1'b1, 2'b10);
        drive(1'b1, 2'b10);
        drive(1'b1, 2'b10);
        tests_run++;
        if (d !== 8'h5A) begin tests_failed++; $display("FAIL midrst_pre_d got=%h exp=5a", d); end
        #5;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (d !== 8'h00 || dv !== 1'b0 || erx !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs d=%h dv=%b erx=%b exp=00/0/0", d, dv, erx);
        end
        repeat (3) @(posedge c);
        @(negedge c);
        rst_n = 1'b1;
        // Remainder of the aborted frame; these bytes contain no preamble dibit.
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'hFF);
        idle(10);
        tests_run++;
        if (rx_bytes.size() != 2 || erx_cnt != 0) begin
            tests_failed++;
            $display("FAIL midrst_ignored dv_count=%0d erx_count=%0d exp=2/0", rx_bytes.size(), erx_cnt);
        end
        clear_mon();
        tx = '{8'h81, 8'h7E};
        send_frame();
        idle(8);
        tests_run++;
        if (rx_bytes.size() != 2 || rx_bytes[0] !== 8'h81 || rx_bytes[1] !== 8'h7E || erx_cnt != 1) begin
            tests_failed++;
            $display("FAIL midrst_next got=%p erx_count=%0d exp=81,7e/1", rx_bytes, erx_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_frame();
        test_partial();
        test_preamble_only();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
